// File: rtl/tone_pkg.sv
// Shared constants and helpers for the tone mixer.
package tone_pkg;

  // Nominal system clock frequency in Hz.
  localparam int unsigned CLK_HZ = 27_000_000;

  // Half-period divisor for a tone frequency in Hz. A frequency of 0 returns 0,
  // which turns the channel off.
  function automatic int unsigned div_from_freq(input int unsigned freq_hz);
    if (freq_hz == 0) begin
      return 0;
    end
    return CLK_HZ / (2 * freq_hz);
  endfunction

endpackage

// File: rtl/tone_channel.sv
// One square-wave tone channel. It holds the half-period counter, the active
// and pending divisors, and the volume register.
// A divisor written while the channel runs waits until the counter wraps.
// This keeps every half-period whole.
module tone_channel
  import tone_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int VOL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [DIV_W-1:0] wr_div,
  input  logic [VOL_W-1:0] wr_vol,
  output logic             tone_out,
  output logic [VOL_W-1:0] vol_out
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div_act;
  logic [DIV_W-1:0] r_div_pend;
  logic             r_pend;
  logic             r_tone;
  logic [VOL_W-1:0] r_vol;

  logic w_running;
  logic w_wrap;

  // The channel runs whenever it has a non-zero active divisor.
  // It wraps on the last count of each half-period.
  always_comb begin
    w_running = (r_div_act != '0);
    w_wrap    = w_running && (r_cnt == (r_div_act - DIV_W'(1)));
  end

  // Counter, divisor hand-over and tone toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_div_act  <= '0;
      r_div_pend <= '0;
      r_pend     <= 1'b0;
      r_tone     <= 1'b0;
      r_vol      <= '0;
    end else begin
      if (wr_en) begin
        r_vol <= wr_vol;
      end
      if (!w_running) begin
        // An idle channel takes a new divisor at once.
        // It starts counting from zero with the tone low.
        r_cnt  <= '0;
        r_tone <= 1'b0;
        if (wr_en) begin
          r_div_act <= wr_div;
        end
      end else if (w_wrap) begin
        r_cnt <= '0;
        if (r_pend) begin
          r_div_act <= r_div_pend;
          r_pend    <= 1'b0;
          // A pending zero stops the channel. The output is forced low here
          // rather than toggled.
          r_tone    <= (r_div_pend == '0) ? 1'b0 : ~r_tone;
        end else begin
          r_tone <= ~r_tone;
        end
        // A write on the wrap cycle is queued for the next wrap.
        if (wr_en) begin
          r_div_pend <= wr_div;
          r_pend     <= 1'b1;
        end
      end else begin
        r_cnt <= r_cnt + DIV_W'(1);
        if (wr_en) begin
          r_div_pend <= wr_div;
          r_pend     <= 1'b1;
        end
      end
    end
  end

  assign tone_out = r_tone;
  assign vol_out  = r_vol;

endmodule

// File: rtl/tone_mixer.sv
// Multi-channel tone generator with a first-order sigma-delta output.
// Write interface: wr_en is a single-cycle strobe with no back-pressure.
// wr_ch, wr_div and wr_vol are sampled only on that cycle.
// A channel index of NUM_CH or above matches no channel, so that write is dropped.
module tone_mixer
  import tone_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int DIV_W  = 16,
  parameter  int VOL_W  = 4,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int SUM_W  = VOL_W + $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [DIV_W-1:0]  wr_div,
  input  logic [VOL_W-1:0]  wr_vol,
  output logic [NUM_CH-1:0] tone_out,
  output logic              audio_out
);

  logic [NUM_CH-1:0] w_tone;
  logic [VOL_W-1:0]  w_vol [NUM_CH];
  logic [SUM_W-1:0]  w_sum;
  logic [SUM_W:0]    w_add;

  logic [SUM_W-1:0]  r_sum;
  logic [SUM_W-1:0]  r_acc;
  logic              r_audio;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic w_sel;
    assign w_sel = wr_en && (wr_ch == CH_W'(g));

    tone_channel #(
      .DIV_W(DIV_W),
      .VOL_W(VOL_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (w_sel),
      .wr_div  (wr_div),
      .wr_vol  (wr_vol),
      .tone_out(w_tone[g]),
      .vol_out (w_vol[g])
    );
  end

  // Volume-weighted sum of the channels whose tone is currently high.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_tone[i]) begin
        w_sum = w_sum + SUM_W'(w_vol[i]);
      end
    end
  end

  // The accumulator adds the sum each cycle. Its carry out is the 1-bit pulse density.
  always_comb begin
    w_add = {1'b0, r_acc} + {1'b0, r_sum};
  end

  // Mixer pipeline: stage 1 registers the sum.
  // Stage 2 registers the accumulator and the carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum   <= '0;
      r_acc   <= '0;
      r_audio <= 1'b0;
    end else begin
      r_sum   <= w_sum;
      r_acc   <= w_add[SUM_W-1:0];
      r_audio <= w_add[SUM_W];
    end
  end

  assign tone_out  = w_tone;
  assign audio_out = r_audio;

endmodule

// File: tb/tb_tone_mixer.sv
// Directed testbench for tone_mixer with 4 channels, 16-bit divisors and 4-bit volumes.
module tb_tone_mixer;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 16;
  localparam int VOL_W  = 4;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [CH_W-1:0]   wr_ch = '0;
  logic [DIV_W-1:0]  wr_div = '0;
  logic [VOL_W-1:0]  wr_vol = '0;
  logic [NUM_CH-1:0] tone_out;
  logic              audio_out;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  tone_mixer #(
    .NUM_CH(NUM_CH),
    .DIV_W (DIV_W),
    .VOL_W (VOL_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_div   (wr_div),
    .wr_vol   (wr_vol),
    .tone_out (tone_out),
    .audio_out(audio_out)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic write(input int ch, input int div, input int vol);
    wr_en  = 1'b1;
    wr_ch  = CH_W'(ch);
    wr_div = DIV_W'(div);
    wr_vol = VOL_W'(vol);
    tick();
    wr_en  = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Count the edges until tone_out[ch] changes. The count is bounded by limit.
  task automatic wait_toggle(input int ch, input int limit, output int n);
    logic start;
    start = tone_out[ch];
    n = 0;
    while (tone_out[ch] == start && n <= limit) begin
      tick();
      n++;
    end
  endtask

  // Pop the next expected half-period and measure it on channel ch.
  task automatic check_interval(input string tag, input int ch);
    logic [31:0] exp;
    int n;
    exp = exp_q.pop_front();
    wait_toggle(ch, 2 * int'(exp) + 10, n);
    check(tag, n, exp);
  endtask

  task automatic count_ones(input int len, output int ones);
    ones = 0;
    repeat (len) begin
      tick();
      if (audio_out) ones++;
    end
  endtask

  initial begin
    int   n;
    int   bad;
    logic t_now;
    logic t_exp;

    // Reset state.
    rst = 1'b1;
    repeat (3) tick();
    check("reset_tone", tone_out, 0);
    check("reset_audio", audio_out, 0);
    rst = 1'b0;
    tick();

    // Channel 0 at 1 kHz. Both half-periods are 13500 cycles.
    write(0, tone_pkg::div_from_freq(1000), 15);
    exp_q.push_back(13500);
    exp_q.push_back(13500);
    check_interval("ch0_first_half", 0);
    check("ch0_high", tone_out[0], 1);
    check_interval("ch0_second_half", 0);
    check("ch0_low", tone_out[0], 0);

    // Channel 1 runs at divisor 100 and gets divisor 50 mid half-period.
    // The current half-period must still last 100 cycles.
    reset_dut();
    write(1, 100, 0);
    exp_q.push_back(100);
    check_interval("ch1_first_half", 1);
    repeat (40) tick();
    write(1, 50, 0);
    exp_q.push_back(59);
    exp_q.push_back(50);
    exp_q.push_back(50);
    check_interval("ch1_rest_of_100", 1);
    check_interval("ch1_new_50_a", 1);
    check_interval("ch1_new_50_b", 1);
    count_ones(64, n);
    check("ch1_muted_audio", n, 0);

    // Write on the wrap cycle: the older pending value applies at this wrap.
    // The new value waits for the next wrap.
    reset_dut();
    write(3, 5, 0);
    exp_q.push_back(5);
    check_interval("ch3_first_half", 3);
    tick();
    write(3, 8, 0);
    tick();
    tick();
    t_now = tone_out[3];
    t_exp = ~t_now;
    write(3, 3, 0);
    check("ch3_wrap_toggle", tone_out[3], t_exp);
    exp_q.push_back(8);
    exp_q.push_back(3);
    check_interval("ch3_older_pending", 3);
    check_interval("ch3_newer_pending", 3);

    // Channel 2 is stopped by writing 0 during its high phase.
    reset_dut();
    write(2, 10, 0);
    exp_q.push_back(10);
    check_interval("ch2_first_half", 2);
    check("ch2_high", tone_out[2], 1);
    repeat (3) tick();
    write(2, 0, 0);
    exp_q.push_back(6);
    check_interval("ch2_stop_at_wrap", 2);
    check("ch2_low_after_stop", tone_out[2], 0);
    bad = 0;
    repeat (40) begin
      tick();
      if (tone_out[2] !== 1'b0) bad++;
    end
    check("ch2_no_glitch", bad, 0);

    // Only channel 0 is high. Volume 8 gives 8 ones per 64 cycles, volume 4 gives 4.
    reset_dut();
    write(0, 200, 8);
    exp_q.push_back(200);
    check_interval("ch0_mix_first_half", 0);
    repeat (8) tick();
    count_ones(64, n);
    check("density_vol8", n, 8);
    write(0, 200, 4);
    repeat (4) tick();
    count_ones(64, n);
    check("density_vol4", n, 4);

    // All four channels at divisor 1 and volume 15, in phase. The sum
    // alternates between 60 and 0, so there are 30 ones per 64 cycles.
    reset_dut();
    write(0, 1, 15);
    tick();
    write(1, 1, 15);
    tick();
    write(2, 1, 15);
    tick();
    write(3, 1, 15);
    repeat (4) tick();
    bad = 0;
    n = 0;
    repeat (64) begin
      tick();
      if (tone_out !== 4'hF && tone_out !== 4'h0) bad++;
      if (audio_out) n++;
    end
    check("all_ch_in_phase", bad, 0);
    check("density_all_ch", n, 30);

    // Reset mid-tone with a pending divisor. A write during reset is dropped.
    reset_dut();
    write(1, 20, 15);
    exp_q.push_back(20);
    check_interval("ch1_pre_reset", 1);
    repeat (2) tick();
    write(1, 7, 15);
    repeat (3) tick();
    rst    = 1'b1;
    wr_en  = 1'b1;
    wr_ch  = 2'd2;
    wr_div = 16'd3;
    wr_vol = 4'd15;
    tick();
    wr_en  = 1'b0;
    rst    = 1'b0;
    check("midreset_tone", tone_out, 0);
    check("midreset_audio", audio_out, 0);
    bad = 0;
    repeat (40) begin
      tick();
      if (tone_out !== 4'h0 || audio_out !== 1'b0) bad++;
    end
    check("stay_off_after_reset", bad, 0);
    write(1, 4, 15);
    exp_q.push_back(4);
    exp_q.push_back(4);
    check_interval("ch1_post_reset_a", 1);
    check_interval("ch1_post_reset_b", 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tone_mixer.md
TONE_MIXER -- requirements
Module: tone_mixer

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent tone channels (1..16).
REQ-002 Parameter DIV_W, default 16: width of per-channel half-period divisor.
REQ-003 Parameter VOL_W, default 4: width of per-channel volume.
REQ-004 Derived: CH_W = max(1, clog2(NUM_CH)); SUM_W = VOL_W + clog2(NUM_CH) (min VOL_W).
REQ-005 clk  input  1  single system clock, 27 MHz nominal.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 wr_en  input  1  one-cycle write strobe for a channel's configuration.
REQ-008 wr_ch  input  CH_W  channel index written; indices >= NUM_CH are ignored.
REQ-009 wr_div  input  DIV_W  half-period in clk cycles; 0 = channel off.
REQ-010 wr_vol  input  VOL_W  channel volume; 0 = muted (tone still runs).
REQ-011 tone_out  output  NUM_CH  raw square wave per channel.
REQ-012 audio_out  output  1  first-order sigma-delta mix of all channels.

Function
REQ-013 Each channel: counter cnt[DIV_W], active divisor div_act, pending divisor div_pend, pending flag, volume vol.
REQ-014 Channel with div_act != 0: cnt increments each cycle; when cnt == div_act-1, cnt <= 0 and tone_out[ch] toggles; period = 2*div_act cycles.
REQ-015 Channel with div_act == 0: cnt held 0, tone_out[ch] held 0.
REQ-016 Write to an off channel (div_act == 0): div_act <= wr_div, cnt <= 0, tone_out stays 0 that cycle; first toggle occurs wr_div cycles after the write cycle.
REQ-017 Write to a running channel: wr_div latched into div_pend, pending set; applied (div_act <= div_pend, pending cleared) on the cycle cnt wraps, together with the toggle -- no shortened/runt half-period.
REQ-018 Write of 0 to a running channel is pending like any divisor; at the wrap the channel goes off and tone_out forced 0 (no final toggle to 1).
REQ-019 Second write before a pending divisor applies overwrites div_pend (last write wins).
REQ-020 Write on the same cycle as a wrap: the wrap applies any older pending value; new value becomes pending for the next wrap.
REQ-021 wr_vol takes effect on the cycle after the write, regardless of phase.
REQ-022 Mixer stage 1 (registered): sum <= sum over ch of (tone_out[ch] ? vol[ch] : 0), SUM_W bits, cannot overflow.
REQ-023 Mixer stage 2: acc[SUM_W] register; {carry, acc} <= acc + sum; audio_out <= carry (registered).
REQ-024 Latency tone_out change -> audio_out density change: 2 cycles.
REQ-025 Long-run density of audio_out equals sum / 2^SUM_W exactly (error bounded by 1 pulse).
REQ-026 All channels independent; simultaneous wraps on any set of channels are legal.

Reset
REQ-027 On rst high at a clk edge: all cnt, div_act, div_pend, pending, vol, sum, acc cleared; tone_out = 0, audio_out = 0 next cycle.
REQ-028 wr_en ignored while rst high; reset mid-tone aborts immediately with no completing half-period.

Structure
REQ-029 Shared package tone_pkg holds CLK_HZ (27_000_000) and helper function for divisor from frequency (CLK_HZ/(2*f)).
REQ-030 Sub-module tone_channel (one channel: counter, pending divisor, volume), instantiated NUM_CH times by generate; mixer lives in tone_mixer.

Verification
REQ-031 NUM_CH=4; write ch0 div=13500 vol=15 -> tone_out[0] toggles every 13500 cycles, first toggle 13500 cycles after write.
REQ-032 ch1 running div=100; at cnt=40 write div=50 -> current half-period stays 100 cycles, following half-periods 50.
REQ-033 ch2 running div=10; write div=0 -> channel stops at next wrap, tone_out[2] = 0 thereafter, never glitches high.
REQ-034 Only ch0 on, tone_out[0]=1, vol=8, SUM_W=6 -> audio_out averages 8/64 (exactly 8 ones per 64 cycles over steady high phase).
REQ-035 All 4 channels div=1 vol=15, constant toggling; assert sum never exceeds 60 and audio_out density matches sum/64.
REQ-036 Assert rst mid-tone with pending divisor -> next cycle all outputs 0, pending cleared; after release channels stay off until written.
